fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter MAX_WAIT, default 16, cycles a fetch may wait for imem_ready before fetch_error sets.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address, equals pc.
REQ-007 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-008 imem_ready  input  1  memory returns data this cycle.
REQ-009 stall  input  1  downstream not ready, hold current instruction.
REQ-010 branch  input  1  Branch signal from the general control unit.
REQ-011 zero  input  1  ALU zero flag for the issued instruction.
REQ-012 instr  output  32  captured instruction word.
REQ-013 opcode  output  6  instr[31:26], drives the control unit Op input.
REQ-014 instr_valid  output  1  instr/opcode/pc are valid this cycle.
REQ-015 pc  output  32  address of the held instruction.
REQ-016 fetch_error  output  1  sticky memory-timeout flag.

Function
REQ-017 FSM states: FETCH, ISSUE, ERROR. Reset state is FETCH.
REQ-018 FETCH: imem_req=1, instr_valid=0. On imem_ready=1, capture imem_rdata into instr and go to ISSUE next cycle.
REQ-019 imem_ready=1 in the first FETCH cycle completes the fetch; latency from FETCH entry to instr_valid is 1 cycle minimum.
REQ-020 ISSUE: imem_req=0, instr_valid=1. With stall=1, stay in ISSUE holding instr, pc and opcode unchanged.
REQ-021 ISSUE with stall=0: update pc and go to FETCH next cycle.
REQ-022 PC update: if branch=1 and zero=1, pc <= pc + 4 + (sign_extend(instr[15:0]) << 2); otherwise pc <= pc + 4.
REQ-023 branch and zero are sampled only in ISSUE with stall=0. They are ignored in all other states.
REQ-024 All PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. pc[1:0] is always 2'b00.
REQ-025 imem_ready outside FETCH is ignored; instr is not modified.
REQ-026 Wait counter: clears on FETCH entry and increments each FETCH cycle with imem_ready=0.
REQ-027 When the wait counter reaches MAX_WAIT without imem_ready, go to ERROR and set fetch_error.
REQ-028 ERROR: imem_req=0, instr_valid=0. Exit only by reset.
REQ-029 stall has no effect in FETCH; the fetch proceeds, and stall is then honoured in ISSUE.

Reset
REQ-030 While reset=1 at a rising edge: pc=RESET_PC, state=FETCH, instr=32'h0, instr_valid=0, fetch_error=0, wait counter=0.
REQ-031 Reset in any state, including mid-fetch, abandons the outstanding request. A same-cycle imem_ready is not captured.
REQ-032 imem_req is asserted in the first cycle after reset deasserts.

Structure
REQ-033 Shared package contents: the opcode constants (RTYPE 000000, LW 100011, SW 101011, BRANCH 000100, ADDI 001000, ADDIU 001001), the FSM state encoding, and the default RESET_PC.
REQ-034 One combinational sub-module, pc_next_calc, computes the next PC from pc, instr[15:0], branch and zero.

Verification
REQ-035 Sequential fetch: reset, imem_ready=1 every FETCH cycle. imem_addr shows 0x0, 0x4, 0x8; instr_valid pulses every 2nd cycle.
REQ-036 Branch taken: at pc=0x10, instr=0x1000_FFFE (beq), branch=1, zero=1 in ISSUE. Next imem_addr=0x0C.
REQ-037 Branch not taken: same instruction with zero=0. Next imem_addr=0x14.
REQ-038 Stall: stall=1 for 3 ISSUE cycles. instr_valid stays 1 and pc/instr are constant; the next fetch begins 1 cycle after stall drops.
REQ-039 Timeout: imem_ready held 0 with MAX_WAIT=4. fetch_error=1 after 4 FETCH cycles, imem_req=0 thereafter, and both clear on reset.
REQ-040 Wrap and mid-fetch reset: RESET_PC=0xFFFF_FFFC gives a second fetch at 0x0. Reset asserted with imem_ready=1 gives instr=0 and imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared definitions for the instruction fetch slice:
//   - opcode constants decoded by the downstream control unit
//   - FSM state encoding of the fetch unit
//   - default reset PC and default memory wait budget
//   - branch_offset(): sign-extended, word-scaled branch displacement
package fetch_unit_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [5:0] OP_BRANCH = 6'b000100;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_ADDIU  = 6'b001001;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_ISSUE = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int          DEFAULT_MAX_WAIT = 16;

   // 16-bit immediate -> 32-bit byte displacement (word offset times 4).
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Instruction-memory read bus between the fetch unit and the memory.
//   imem_req   : read request (fetch unit -> memory)
//   imem_addr  : word-aligned read address (fetch unit -> memory)
//   imem_rdata : instruction word, valid with imem_ready (memory -> fetch unit)
//   imem_ready : memory returns data this cycle (memory -> fetch unit)
//   master modport = fetch unit side, slave modport = memory side.
interface fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );

endinterface

// File: rtl/fetch_unit_pc_next_calc.sv
// pc_next_calc
//   Purely combinational next-PC computation.
//   pc      : address of the instruction being retired
//   imm     : instr[15:0], branch displacement in words
//   branch  : branch control from the control unit
//   zero    : ALU zero flag
//   pc_next : pc + 4, plus the scaled displacement when branch and zero are set
//   All arithmetic wraps modulo 2^32.
module pc_next_calc
   import fetch_unit_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [15:0] imm,
   input  logic        branch,
   input  logic        zero,
   output logic [31:0] pc_next
);

   logic [31:0] pc_plus4;

   assign pc_plus4 = pc + 32'd4;
   assign pc_next  = (branch && zero) ? (pc_plus4 + branch_offset(imm)) : pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Single-outstanding instruction fetcher with a FETCH / ISSUE / ERROR FSM.
//   Parameters:
//     RESET_PC : address of the first fetch after reset
//     MAX_WAIT : FETCH cycles without imem_ready before fetch_error sets
//   Ports:
//     clk, reset  : clock and synchronous active-high reset
//     mem         : instruction-memory bus (master side)
//     stall       : downstream not ready, hold the issued instruction
//     branch,zero : branch decision inputs, used only when leaving ISSUE
//     instr       : captured instruction word
//     opcode      : instr[31:26]
//     instr_valid : instr/opcode/pc valid (ISSUE state)
//     pc          : address of the held instruction, also the fetch address
//     fetch_error : sticky memory timeout flag, cleared only by reset
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          MAX_WAIT = DEFAULT_MAX_WAIT
)
(
   input  logic               clk,
   input  logic               reset,
   fetch_unit_if.master       mem,
   input  logic               stall,
   input  logic               branch,
   input  logic               zero,
   output logic [31:0]        instr,
   output logic [5:0]         opcode,
   output logic               instr_valid,
   output logic [31:0]        pc,
   output logic               fetch_error
);

   // Counter must be able to hold MAX_WAIT itself.
   localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   state_t            state_reg;
   state_t            state_next;
   logic [31:0]       pc_reg;
   logic [31:0]       pc_next;
   logic [31:0]       instr_reg;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic              fetch_error_reg;
   logic              wait_expired;

   // True on the FETCH cycle that would bring the counter up to MAX_WAIT.
   assign wait_expired = (wait_cnt_reg == WAIT_LAST);

   pc_next_calc u_pc_next_calc (
      .pc      (pc_reg),
      .imm     (instr_reg[15:0]),
      .branch  (branch),
      .zero    (zero),
      .pc_next (pc_next)
   );

   // ---- FSM: state register ----
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---- FSM: next-state logic ----
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_FETCH: begin
            if (mem.imem_ready) begin
               state_next = ST_ISSUE;
            end else if (wait_expired) begin
               state_next = ST_ERROR;
            end
         end
         ST_ISSUE: begin
            if (!stall) begin
               state_next = ST_FETCH;
            end
         end
         ST_ERROR: begin
            state_next = ST_ERROR;
         end
         default: begin
            state_next = ST_FETCH;
         end
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      mem.imem_req = 1'b0;
      instr_valid  = 1'b0;
      case (state_reg)
         ST_FETCH: mem.imem_req = 1'b1;
         ST_ISSUE: instr_valid  = 1'b1;
         default: begin
            mem.imem_req = 1'b0;
            instr_valid  = 1'b0;
         end
      endcase
   end

   // ---- datapath: pc, instruction, wait counter, error flag ----
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg          <= {RESET_PC[31:2], 2'b00};
         instr_reg       <= 32'h0;
         wait_cnt_reg    <= '0;
         fetch_error_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_FETCH: begin
               if (mem.imem_ready) begin
                  instr_reg <= mem.imem_rdata;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                  if (wait_expired) begin
                     fetch_error_reg <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               // Leaving ISSUE is the only way into FETCH, so the counter
               // is cleared here to start every fetch from zero.
               if (!stall) begin
                  pc_reg       <= pc_next;
                  wait_cnt_reg <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign mem.imem_addr = pc_reg;
   assign pc            = pc_reg;
   assign instr         = instr_reg;
   assign opcode        = instr_reg[31:26];
   assign fetch_error   = fetch_error_reg;

endmodule
